// File: rtl/ibex_fp_pkg.sv
// ----------------------------------------------------------------------------
// ibex_fp_pkg
// Shared definitions for the floating-point register file and scoreboard:
//   NumRegs       - number of architectural FP registers
//   FpAddrW       - FP register address width
//   fp_reg_addr_t - FP register address type
//   fpu_op_e      - FPU operation encoding used by the issue path
// ----------------------------------------------------------------------------
package ibex_fp_pkg;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned FpAddrW = $clog2(NumRegs);

  typedef logic [FpAddrW-1:0] fp_reg_addr_t;

  typedef enum logic [3:0] {
    FPU_OP_FMADD  = 4'd0,
    FPU_OP_FNMSUB = 4'd1,
    FPU_OP_ADD    = 4'd2,
    FPU_OP_MUL    = 4'd3,
    FPU_OP_DIV    = 4'd4,
    FPU_OP_SQRT   = 4'd5,
    FPU_OP_SGNJ   = 4'd6,
    FPU_OP_MINMAX = 4'd7,
    FPU_OP_CMP    = 4'd8,
    FPU_OP_CLASS  = 4'd9,
    FPU_OP_F2I    = 4'd10,
    FPU_OP_I2F    = 4'd11
  } fpu_op_e;

endpackage

// File: rtl/fp_sb_popcount.sv
// ----------------------------------------------------------------------------
// fp_sb_popcount
// Purely combinational population count of the scoreboard busy vector.
// Ports:
//   vec_i  [Width]    input bit vector
//   cnt_o  [CntW]     number of set bits, 0..Width (wide enough, never wraps)
// ----------------------------------------------------------------------------
module fp_sb_popcount #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] vec_i,
  output logic [CntW-1:0]  cnt_o
);

  // Add one bit at a time; synthesis folds this into an adder tree.
  always_comb begin
    cnt_o = {CntW{1'b0}};
    for (int unsigned i = 0; i < Width; i++) begin
      cnt_o = cnt_o + {{(CntW-1){1'b0}}, vec_i[i]};
    end
  end

endmodule

// File: rtl/fp_regfile_sb.sv
// ----------------------------------------------------------------------------
// fp_regfile_sb
// FP register file (3 combinational read ports with write-through, FPU and
// LSU write ports, FPU priority) plus an issue scoreboard that tracks pending
// writes and gates issue on RAW / WAW hazards.
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   raddr_{a,b,c}_i / rdata_{a,b,c}_o      rs1/rs2/rs3 read ports
//   issue_valid_i, issue_rd_i,
//   issue_fp_dest_i, issue_ready_o         issue handshake
//   fpu_we_i/fpu_waddr_i/fpu_wdata_i       FPU writeback (priority)
//   lsu_we_i/lsu_waddr_i/lsu_wdata_i       load writeback
//   lsu_gnt_o                              LSU write accepted this cycle
//   busy_o, pending_cnt_o                  scoreboard and its popcount
// ----------------------------------------------------------------------------
module fp_regfile_sb #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumRegs   = ibex_fp_pkg::NumRegs,
  parameter int unsigned AddrW     = $clog2(NumRegs),
  parameter int unsigned CntW      = $clog2(NumRegs + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrW-1:0]     raddr_a_i,
  input  logic [AddrW-1:0]     raddr_b_i,
  input  logic [AddrW-1:0]     raddr_c_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic [DataWidth-1:0] rdata_c_o,
  input  logic                 issue_valid_i,
  input  logic [AddrW-1:0]     issue_rd_i,
  input  logic                 issue_fp_dest_i,
  output logic                 issue_ready_o,
  input  logic                 fpu_we_i,
  input  logic [AddrW-1:0]     fpu_waddr_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  input  logic                 lsu_we_i,
  input  logic [AddrW-1:0]     lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_gnt_o,
  output logic [NumRegs-1:0]   busy_o,
  output logic [CntW-1:0]      pending_cnt_o
);

  logic [DataWidth-1:0] r_regs [NumRegs];
  logic [NumRegs-1:0]   r_busy;
  logic [CntW-1:0]      r_cnt;

  logic                 w_lsu_gnt;
  logic [NumRegs-1:0]   w_clr;
  logic [NumRegs-1:0]   w_set;
  logic [NumRegs-1:0]   w_busy_eff;
  logic [NumRegs-1:0]   w_busy_next;
  logic [CntW-1:0]      w_cnt_next;
  logic                 w_ready;

  // Write-through read: the FPU write wins; LSU data is only visible when granted.
  function automatic logic [DataWidth-1:0] read_port(
    input logic [AddrW-1:0] addr
  );
    logic [DataWidth-1:0] d;
    if (fpu_we_i && (fpu_waddr_i == addr)) begin
      d = fpu_wdata_i;
    end else if (w_lsu_gnt && (lsu_waddr_i == addr)) begin
      d = lsu_wdata_i;
    end else begin
      d = r_regs[addr];
    end
    return d;
  endfunction

  assign w_lsu_gnt = lsu_we_i & ~fpu_we_i;

  // Per-register retire (clear) and issue (set) strobes for this cycle.
  always_comb begin
    w_clr = {NumRegs{1'b0}};
    w_set = {NumRegs{1'b0}};
    for (int unsigned n = 0; n < NumRegs; n++) begin
      w_clr[n] = (fpu_we_i  && (fpu_waddr_i == AddrW'(n))) ||
                 (w_lsu_gnt && (lsu_waddr_i == AddrW'(n)));
      w_set[n] = issue_valid_i && w_ready && issue_fp_dest_i &&
                 (issue_rd_i == AddrW'(n));
    end
  end

  // A bit retired this cycle no longer blocks issue (clear-bypass).
  assign w_busy_eff = r_busy & ~w_clr;

  // Hazard check: RAW on all three sources, WAW on the FP destination.
  always_comb begin
    w_ready = ~(w_busy_eff[raddr_a_i] | w_busy_eff[raddr_b_i] |
                w_busy_eff[raddr_c_i] |
                (issue_fp_dest_i & w_busy_eff[issue_rd_i]));
  end

  // Set is OR-ed after the clear so a new producer wins over a retiring one.
  assign w_busy_next = w_busy_eff | w_set;

  fp_sb_popcount #(
    .Width (NumRegs),
    .CntW  (CntW)
  ) u_popcount (
    .vec_i (w_busy_next),
    .cnt_o (w_cnt_next)
  );

  // Register file storage; FPU and granted LSU never target a cycle together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        r_regs[i] <= {DataWidth{1'b0}};
      end
    end else begin
      if (fpu_we_i) begin
        r_regs[fpu_waddr_i] <= fpu_wdata_i;
      end
      if (w_lsu_gnt) begin
        r_regs[lsu_waddr_i] <= lsu_wdata_i;
      end
    end
  end

  // Scoreboard and its count update on the same edge so they always agree.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= {NumRegs{1'b0}};
      r_cnt  <= {CntW{1'b0}};
    end else begin
      r_busy <= w_busy_next;
      r_cnt  <= w_cnt_next;
    end
  end

  assign rdata_a_o     = read_port(raddr_a_i);
  assign rdata_b_o     = read_port(raddr_b_i);
  assign rdata_c_o     = read_port(raddr_c_i);
  assign issue_ready_o = w_ready;
  assign lsu_gnt_o     = w_lsu_gnt;
  assign busy_o        = r_busy;
  assign pending_cnt_o = r_cnt;

endmodule

// File: tb/tb_fp_regfile_sb.sv
module tb_fp_regfile_sb;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  raddr_a_i, raddr_b_i, raddr_c_i;
  logic [31:0] rdata_a_o, rdata_b_o, rdata_c_o;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_fp_dest_i;
  logic        issue_ready_o;
  logic        fpu_we_i;
  logic [4:0]  fpu_waddr_i;
  logic [31:0] fpu_wdata_i;
  logic        lsu_we_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic [31:0] busy_o;
  logic [5:0]  pending_cnt_o;

  fp_regfile_sb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
    .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o), .rdata_c_o(rdata_c_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .issue_fp_dest_i(issue_fp_dest_i), .issue_ready_o(issue_ready_o),
    .fpu_we_i(fpu_we_i), .fpu_waddr_i(fpu_waddr_i), .fpu_wdata_i(fpu_wdata_i),
    .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_gnt_o(lsu_gnt_o), .busy_o(busy_o), .pending_cnt_o(pending_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a, b, c;
    logic        rdy, gnt;
    logic [31:0] busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: architectural register values and pending-write flags.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One clock of stimulus: drive, predict, enqueue, advance the model.
  task automatic cycle(input logic v, input logic [4:0] rd, input logic fd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                       input logic fwe, input logic [4:0] fwa, input logic [31:0] fwd,
                       input logic lwe, input logic [4:0] lwa, input logic [31:0] lwd);
    exp_t e;
    bit   gnt, rdy;
    bit   ret [32];
    int   n;
    logic [4:0] addrs [3];
    logic [31:0] vals [3];
    @(negedge clk_i);
    issue_valid_i = v; issue_rd_i = rd; issue_fp_dest_i = fd;
    raddr_a_i = ra; raddr_b_i = rb; raddr_c_i = rc;
    fpu_we_i = fwe; fpu_waddr_i = fwa; fpu_wdata_i = fwd;
    lsu_we_i = lwe; lsu_waddr_i = lwa; lsu_wdata_i = lwd;

    gnt = lwe && !fwe;
    for (int i = 0; i < 32; i++)
      ret[i] = (fwe && int'(fwa) == i) || (gnt && int'(lwa) == i);
    addrs[0] = ra; addrs[1] = rb; addrs[2] = rc;
    for (int k = 0; k < 3; k++) begin
      if (fwe && fwa == addrs[k])      vals[k] = fwd;
      else if (gnt && lwa == addrs[k]) vals[k] = lwd;
      else                             vals[k] = m_regs[addrs[k]];
    end
    rdy = !(m_busy[ra] && !ret[ra]) && !(m_busy[rb] && !ret[rb]) &&
          !(m_busy[rc] && !ret[rc]) && !(fd && m_busy[rd] && !ret[rd]);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      e.busy[i] = m_busy[i];
      n += int'(m_busy[i]);
    end
    e.a = vals[0]; e.b = vals[1]; e.c = vals[2];
    e.rdy = rdy; e.gnt = gnt; e.cnt = n;
    q.push_back(e);

    if (fwe) m_regs[fwa] = fwd;
    if (gnt) m_regs[lwa] = lwd;
    for (int i = 0; i < 32; i++)
      if (ret[i]) m_busy[i] = 1'b0;
    if (v && rdy && fd) m_busy[rd] = 1'b1;
    @(posedge clk_i);
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0; issue_rd_i = 5'd0; issue_fp_dest_i = 1'b0;
    raddr_a_i = 5'd0; raddr_b_i = 5'd0; raddr_c_i = 5'd0;
    fpu_we_i = 1'b0; fpu_waddr_i = 5'd0; fpu_wdata_i = 32'd0;
    lsu_we_i = 1'b0; lsu_waddr_i = 5'd0; lsu_wdata_i = 32'd0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, busy_o, 32'd0);
    chk({tag, "_cnt"}, {26'd0, pending_cnt_o}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      raddr_a_i = 5'(i);
      #1;
      chk({tag, "_reg"}, rdata_a_o, 32'd0);
    end
  endtask

  task automatic random_cycles(input int num);
    for (int i = 0; i < num; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata_a", rdata_a_o, e.a);
        chk("rdata_b", rdata_b_o, e.b);
        chk("rdata_c", rdata_c_o, e.c);
        chk("issue_ready", {31'd0, issue_ready_o}, {31'd0, e.rdy});
        chk("lsu_gnt", {31'd0, lsu_gnt_o}, {31'd0, e.gnt});
        chk("busy", busy_o, e.busy);
        chk("pending_cnt", {26'd0, pending_cnt_o}, e.cnt);
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("reset_ready", {31'd0, issue_ready_o}, 32'd1);
    check_reset_state("init");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // f1 write with same-cycle bypass, then registered read.
    cycle(1'b0, 5'd0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 5'd1, 32'h4023d70a, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 1'b0, 5'd1, 5'd1, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // Address 0 is an ordinary register.
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h3f800000);
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 5'd1, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // Issue rd=5, RAW stall on f5, then clear-bypass on FPU writeback.
    cycle(1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd9, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd9, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 5'd5, 32'h41200000, 1'b0, 5'd0, 32'd0);
    // FPU and LSU collide on f3: FPU wins, LSU not granted.
    cycle(1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b1, 5'd3, 32'h41200000, 1'b1, 5'd3, 32'hc001c0de);
    cycle(1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // Issue rd=7 twice; second one coincides with the f7 writeback -> stays busy.
    cycle(1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h40490fdb, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);

    random_cycles(300);

    // Four producers in flight, then asynchronous reset between edges.
    cycle(1'b1, 5'd10, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd2, 32'hdeadbeef, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd11, 1'b1, 5'd12, 5'd12, 5'd12, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd12, 1'b1, 5'd13, 5'd13, 5'd13, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd13, 1'b1, 5'd14, 5'd14, 5'd14, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3;
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    check_reset_state("midrst");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Late writebacks to the discarded producers are accepted as normal writes.
    cycle(1'b0, 5'd0, 1'b0, 5'd10, 5'd0, 5'd0, 1'b1, 5'd10, 32'h0badf00d, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 1'b0, 5'd10, 5'd11, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h55aa55aa);
    random_cycles(200);

    repeat (3) @(negedge clk_i);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_regfile_sb.md
FP_REGFILE_SB -- requirements
Module: fp_regfile_sb

Interface
REQ-001 SHALL have parameter DataWidth, default 32, FP register width.
REQ-002 SHALL have parameter NumRegs, default 32, number of FP registers; address width is $clog2(NumRegs).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk_i  input  1  the single clock, all state on its rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 raddr_a_i / raddr_b_i / raddr_c_i  input  5 each  rs1/rs2/rs3 read addresses.
REQ-006 rdata_a_o / rdata_b_o / rdata_c_o  output  DataWidth each  rs1/rs2/rs3 operand data to the FPU.
REQ-007 issue_valid_i  input  1  decoder presents an FP instruction.
REQ-008 issue_rd_i  input  5  destination address of the issuing instruction.
REQ-009 issue_fp_dest_i  input  1  destination is the FP file.
REQ-010 issue_ready_o  output  1  operands hazard-free; instruction may issue.
REQ-011 fpu_we_i / fpu_waddr_i / fpu_wdata_i  input  1/5/DataWidth  FPU result writeback.
REQ-012 lsu_we_i / lsu_waddr_i / lsu_wdata_i  input  1/5/DataWidth  FLW load writeback.
REQ-013 lsu_gnt_o  output  1  LSU write accepted this cycle.
REQ-014 busy_o  output  NumRegs  scoreboard, bit n set = write to fn pending.
REQ-015 pending_cnt_o  output  6  number of set busy bits.

Function
REQ-016 Register write SHALL occur on the rising clk_i edge for each accepted write port.
REQ-017 Reads SHALL be combinational, with write-through: a read of an address written this cycle returns the winning write data.
REQ-018 FPU write SHALL have priority: lsu_gnt_o = lsu_we_i & ~fpu_we_i; an ungranted LSU write is dropped and the LSU holds and retries.
REQ-019 Issue handshake SHALL be issue_valid_i & issue_ready_o; on handshake with issue_fp_dest_i=1, busy[issue_rd_i] is set next edge.
REQ-020 Any accepted write to address n SHALL clear busy[n] next edge.
REQ-021 Simultaneous set and clear of the same bit SHALL leave it set (new producer wins).
REQ-022 issue_ready_o SHALL be 0 if busy is set for any of raddr_a/b/c_i (RAW) or, when issue_fp_dest_i=1, for issue_rd_i (WAW), unless that bit is cleared by an accepted write this same cycle (clear-bypass).
REQ-023 pending_cnt_o SHALL equal the registered popcount of busy_o, updated the same edge as busy_o, range 0..32 without wrap.
REQ-024 Address 0 SHALL be an ordinary writable register (no hardwired zero in the FP file).
REQ-025 Write latency SHALL be 1 cycle; read-after-write in the next cycle returns the new value.

Reset
REQ-026 On rst_ni low, all registers SHALL clear to 0 immediately and asynchronously.
REQ-027 On rst_ni low, busy_o SHALL be 0 and pending_cnt_o SHALL be 0; issue_ready_o then follows from the combinational inputs.
REQ-028 Reset asserted mid-operation SHALL discard in-flight busy state; late writebacks after reset are accepted normally.

Structure
REQ-029 NumRegs and the fp register address type SHALL live in ibex_fp_pkg alongside fpu_op_e.
REQ-030 The popcount SHALL be one sub-module, fp_sb_popcount.

Verification
REQ-031 Write f1=0x4023d70a via FPU, then read raddr_a=1 next cycle -> rdata_a_o=0x4023d70a; same cycle -> bypass returns the same value.
REQ-032 Issue with rd=5 (fp dest) -> busy_o[5]=1, pending_cnt_o=1; next issue reading raddr_b=5 -> issue_ready_o=0; FPU writes f5=0x41200000 -> ready=1 in that same cycle.
REQ-033 fpu_we and lsu_we both set, addr=3, data 0x41200000 / 0xc001c0de -> lsu_gnt_o=0, f3=0x41200000.
REQ-034 Issue rd=7 while FPU writes f7 in the same cycle -> busy_o[7] remains 1.
REQ-035 Set 4 busy bits, assert rst_ni low mid-cycle -> busy_o=0, pending_cnt_o=0, all regs 0 without waiting for a clock edge.
